// File: rtl/lsu_pkg.sv
// Shared constants and access-legality check for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE   = 3'd0;
  localparam lsu_state_t ST_LOAD   = 3'd1;
  localparam lsu_state_t ST_RMW_RD = 3'd2;
  localparam lsu_state_t ST_WRITE  = 3'd3;
  localparam lsu_state_t ST_DONE   = 3'd4;

  // True when the request must not reach memory: unknown width code or misaligned.
  function automatic logic lsu_access_fault(input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] byte_off);
    logic legal;
    logic misaligned;
    legal      = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:  legal = 1'b1;
      F3_H:  begin legal = 1'b1; misaligned = byte_off[0]; end
      F3_W:  begin legal = 1'b1; misaligned = |byte_off; end
      F3_BU: legal = !is_store;
      F3_HU: begin legal = !is_store; misaligned = byte_off[0]; end
      default: legal = 1'b0;
    endcase
    return !legal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] old_word,
  input  logic [15:0] wdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (byte_off)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = '0;
    endcase
    half_sel = byte_off[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_B:  load_data = 32'(byte_sel);
      F3_BU: load_data = {24'd0, byte_sel};
      F3_H:  load_data = 32'(half_sel);
      F3_HU: load_data = {16'd0, half_sel};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merge_word = old_word;
    case (funct3)
      F3_B: begin
        case (byte_off)
          2'd0: merge_word[7:0]   = wdata[7:0];
          2'd1: merge_word[15:8]  = wdata[7:0];
          2'd2: merge_word[23:16] = wdata[7:0];
          2'd3: merge_word[31:24] = wdata[7:0];
          default: merge_word = old_word;
        endcase
      end
      F3_H: begin
        if (byte_off[1]) merge_word[31:16] = wdata;
        else             merge_word[15:0]  = wdata;
      end
      default: merge_word = old_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state_q, state_d;
  logic              fault_q, fault_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_store_q, is_store_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0] load_data;
  logic [31:0] merge_word;
  logic        word_store;

  lsu_lane_align u_lane_align (
    .word       (mem_rdata),
    .old_word   (mem_rdata),
    .wdata      (wdata_q[15:0]),
    .byte_off   (addr_q[1:0]),
    .funct3     (funct3_q),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    rdata_d    = rdata_q;
    merge_d    = merge_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    is_store_d = is_store_q;
    wdata_d    = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d     = addr;
          funct3_d   = funct3;
          is_store_d = is_store;
          wdata_d    = wdata;
          fault_d    = lsu_access_fault(is_store, funct3, addr[1:0]);
          if (fault_d)            state_d = ST_DONE;
          else if (!is_store)     state_d = ST_LOAD;
          else if (funct3 == F3_W) state_d = ST_WRITE;
          else                    state_d = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        rdata_d = load_data;
        state_d = ST_DONE;
      end
      ST_RMW_RD: begin
        merge_d = merge_word;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fault_q <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
    end
  end

  // Request fields only matter once captured, so they carry no reset.
  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    funct3_q   <= funct3_d;
    is_store_q <= is_store_d;
    wdata_q    <= wdata_d;
  end

  assign word_store = is_store_q && (funct3_q == F3_W);

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    fault     = done && fault_q;
    rdata     = rdata_q;
    mem_read  = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
    mem_write = (state_q == ST_WRITE) && !rst;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_read || mem_write) mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    if (mem_write)             mem_wdata = word_store ? wdata_q : merge_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-level memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, fault;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_rdata;
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write)  mem[mem_addr[9:2]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic bit m_fault(input bit st, input bit [2:0] f3, input bit [31:0] a);
    bit legal;
    int sz;
    if (st) legal = (f3 <= 3'd2);
    else    legal = (f3 != 3'd3) && (f3 <= 3'd5);
    if (!legal) return 1'b1;
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic bit [31:0] m_load(input bit [31:0] w, input bit [2:0] f3, input bit [31:0] a);
    longint v;
    int sz;
    sz = 1 << f3[1:0];
    v = (longint'(w) >> (8 * (a % 4))) % (longint'(1) << (8 * sz));
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic bit [31:0] m_store(input bit [31:0] old, input bit [31:0] wd,
                                        input bit [2:0] f3, input bit [31:0] a);
    bit [7:0] b [4];
    int sz;
    sz = 1 << f3[1:0];
    for (int i = 0; i < 4; i++)  b[i] = 8'(old >> (8 * i));
    for (int i = 0; i < sz; i++) b[(a % 4) + i] = 8'(wd >> (8 * i));
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic preload(input int idx, input bit [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 8'(idx); pl_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_op(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
    bit flt, got_done;
    int idx, exp_lat, exp_rd, exp_wr, cyc, nrd, nwr;
    bit [31:0] new_word;
    idx      = (a >> 2) & 255;
    flt      = m_fault(st, f3, a);
    new_word = (!flt && st) ? m_store(ref_mem[idx], wd, f3, a) : ref_mem[idx];
    exp_lat  = flt ? 1 : ((!st || f3 == 3'd2) ? 2 : 3);
    exp_rd   = (!flt && !(st && f3 == 3'd2)) ? 1 : 0;
    exp_wr   = (!flt && st) ? 1 : 0;
    @(negedge clk);
    req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0; wdata = $urandom;
    cyc = 1; got_done = 1'b0; nrd = 0; nwr = 0;
    while (!got_done && cyc <= 8) begin
      check("busy", busy, 1);
      check("rd_wr_exclusive", mem_read & mem_write, 0);
      if (mem_read) begin
        nrd++;
        check("rd_addr", mem_addr, {a[31:2], 2'b00});
      end
      if (mem_write) begin
        nwr++;
        check("wr_addr", mem_addr, {a[31:2], 2'b00});
        check("wr_data", mem_wdata, new_word);
      end
      if (done) begin
        got_done = 1'b1;
        check("latency", cyc, exp_lat);
        check("fault", fault, flt);
        if (!flt && !st) exp_rdata = m_load(ref_mem[idx], f3, a);
        check("rdata", rdata, exp_rdata);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", got_done, 1);
    check("read_cycles", nrd, exp_rd);
    check("write_cycles", nwr, exp_wr);
    if (!flt && st) ref_mem[idx] = new_word;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads, dones;
    bit got;
    rst = 1'b1; req = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    exp_rdata = '0;
    for (int i = 0; i < 256; i++) preload(i, $urandom);

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    preload(16, 32'h8899AABB);
    do_op(1'b0, F3_B, 32'h41, 32'h0);
    check("lb_value", rdata, 32'hFFFFFFAA);
    do_op(1'b0, F3_BU, 32'h41, 32'h0);
    check("lbu_value", rdata, 32'h000000AA);
    do_op(1'b0, F3_HU, 32'h42, 32'h0);
    check("lhu_value", rdata, 32'h00008899);

    preload(16, 32'h11223344);
    do_op(1'b1, F3_B, 32'h42, 32'h000000EE);
    check("sb_mem_word", mem[16], 32'h11EE3344);
    check("sb_rdata_held", rdata, 32'h00008899);

    do_op(1'b1, F3_W, 32'h80, 32'hDEADBEEF);
    do_op(1'b0, F3_W, 32'h80, 32'h0);
    check("lw_after_sw", rdata, 32'hDEADBEEF);

    do_op(1'b0, F3_H, 32'h43, 32'h0);
    do_op(1'b0, F3_W, 32'h42, 32'h0);
    do_op(1'b0, 3'b011, 32'h40, 32'h0);
    check("fault_rdata_held", rdata, 32'hDEADBEEF);

    // SH interrupted by reset while reading the old word
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = F3_H; addr = 32'h44; wdata = 32'h0000CAFE;
    @(negedge clk);
    req = 1'b0;
    check("sh_rmw_read", mem_read, 1);
    rst = 1'b1;
    @(negedge clk);
    exp_rdata = '0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_mem_read", mem_read, 0);
    check("mid_rst_mem_write", mem_write, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_write", mem_write, 0);
    end
    check("post_rst_mem_word", mem[17], ref_mem[17]);

    // Request coinciding with reset is dropped
    @(negedge clk);
    rst = 1'b1; req = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h80;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    check("rst_req_dropped_busy", busy, 0);
    check("rst_req_dropped_read", mem_read, 0);

    // Request held high through a whole LW
    @(negedge clk);
    req = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h80;
    reads = 0; dones = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (mem_read) reads++;
      if (done) dones++;
      if (c == 2) check("held_done_at_2", done, 1);
      if (c == 3) check("held_idle_gap", busy, 0);
    end
    check("held_reads", reads, 1);
    check("held_dones", dones, 1);
    @(negedge clk);
    req = 1'b0;
    check("held_second_access", mem_read, 1);
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("held_second_done", got, 1);
    exp_rdata = m_load(ref_mem[32], F3_W, 32'h80);
    check("held_rdata", rdata, exp_rdata);

    for (int n = 0; n < 60; n++) begin
      bit st;
      bit [2:0] f3;
      bit [31:0] a;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h100 + 32'($urandom_range(0, 31));
      do_op(st, f3, a, $urandom);
    end

    for (int i = 0; i < 256; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's data-memory port: accepts one load/store request at a time from the execute stage and drives the word-addressed data memory's `mem_read`/`mem_write`/`address`/`data_in` and receives its `data_out`. Byte and halfword accesses are handled here. Loads get lane extraction plus sign/zero extension. Sub-word stores use a read-modify-write sequence, because the memory only writes whole words. Misaligned or illegal accesses are reported and never reach memory.

## Interface
Parameters:
- `ADDR_W`, 32, core address width; memory word index is `addr[9:2]`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high.
- `req` in 1: request strobe, sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: RV32I width/sign code.
- `addr` in 32: byte address.
- `wdata` in 32: store data, with the valid bytes in the low lanes.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`; misaligned address or illegal funct3.
- `rdata` out 32: extended load result.
- `mem_addr` out 32: word-aligned address `{addr_q[31:2],2'b00}`.
- `mem_wdata` out 32: full word to write.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable.
- `mem_rdata` in 32: memory read data (combinational, valid same cycle as `mem_read`).

## Operation
- Accept: in IDLE with `req`=1, latch `addr`, `funct3`, `is_store`, `wdata`. `req` while `busy` is ignored and is not queued.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other code is a fault.
- Misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0. This is a fault.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, DONE.
  - IDLE → DONE on a faulted request, with no memory access.
  - IDLE → LOAD on a load.
  - IDLE → WRITE on SW.
  - IDLE → RMW_RD on SB/SH.
  - LOAD: `mem_read`=1. At the clock edge, `rdata` ← lane-extracted `mem_rdata`, then → DONE.
  - RMW_RD: `mem_read`=1. At the clock edge, merge register ← `mem_rdata` with the target byte/halfword lanes replaced by `wdata[7:0]`/`wdata[15:0]`, then → WRITE.
  - WRITE: `mem_write`=1. `mem_wdata` = `wdata_q` for SW, otherwise the merge register. Then → DONE.
  - DONE: `done`=1 and `fault` = latched fault flag, then → IDLE.
- Lane select: byte lane = `addr[1:0]`, halfword lane = `addr[1]`. LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend.
- `rdata` updates only on load completion. It holds through stores and faults.
- `mem_addr` and `mem_wdata` are 0 whenever `mem_read` and `mem_write` are both 0.
- `mem_read` and `mem_write` are never high in the same cycle.

## Timing
- Reset: state IDLE. `busy`, `done`, `fault`, `mem_read`, `mem_write` = 0. `rdata`, `mem_addr`, `mem_wdata`, merge register = 0.
- Latency from the `req` cycle to the `done` pulse:
  - Fault: 1 cycle.
  - Load or SW: 2 cycles.
  - SB/SH: 3 cycles.
- Occupancy: the next request can be accepted in the cycle after `done`.
- Reset mid-operation: returns to IDLE on the next edge with no further memory access. `mem_write` is gated by `!rst`, so a WRITE state coinciding with `rst` does not write.
- Only `rst` dominates; `req` arriving in the same cycle as `rst` is dropped.

## Structure
- `lsu_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - State enum.
  - Misalignment/legality function.
- Sub-module `lsu_lane_align`, purely combinational:
  - Load extract/extend from (`word`, `addr[1:0]`, `funct3`).
  - Store merge from (`old_word`, `wdata`, `addr[1:0]`, `funct3`).
  - `load_store_unit` instantiates it once; the FSM, registers and memory-side drive live in the top.

## Test plan
- Memory word 0x40 = 0x8899AABB.
  - LB at 0x41 → `rdata`=0xFFFFFFAA and `done` 2 cycles after `req`.
  - LBU at 0x41 → 0x000000AA.
  - LHU at 0x42 → 0x00008899.
- Word 0x40 = 0x11223344. SB `wdata`=0x000000EE at 0x42:
  - one `mem_read` cycle, then one `mem_write` cycle with `mem_wdata`=0x11EE3344;
  - `done` at +3; `rdata` unchanged.
- SW 0xDEADBEEF at 0x80, then LW 0x80 → 0xDEADBEEF. The SW shows no `mem_read` cycle.
- LH at 0x43, LW at 0x42, and funct3=011 load:
  - each gives `done`=1 and `fault`=1 one cycle after `req`;
  - `mem_read`/`mem_write` stay 0; `rdata` holds its previous value.
- SH `req` followed by `rst` asserted during RMW_RD:
  - no `mem_write` ever asserts;
  - all outputs return to 0 after the reset edge.
- `req` held high across a whole LW: exactly one access and one `done`. A new access starts only after the IDLE cycle.
